// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave backed by an on-chip word array with a fixed request-to-completion latency.
// Each transfer is classified as legal or erroring when it is accepted; erroring transfers complete normally, return zero and set a sticky err flag.
module avalon_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h00001000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q;
    logic            bad_q;
    logic            is_wr_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic [31:0]     readdata_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     offset;
    logic            live_legal;
    logic            live_bad;
    logic [AW-1:0]   live_idx;
    logic [AW-1:0]   cur_idx;
    logic            cur_bad;
    logic            cur_wr;
    logic            accept;
    logic            enter_done;

    // Decode the live bus address; only used in IDLE when the request is captured.
    assign offset     = address - BASE_ADDR;
    assign live_legal = (address >= BASE_ADDR) && ({1'b0, offset} < SPAN) && (address[1:0] == 2'b00);
    assign live_bad   = !live_legal || (read && write);
    assign live_idx   = offset[AW+1:2];

    assign accept     = (state_q == IDLE) && (read || write);

    // With LATENCY=1 DONE is entered on the acceptance edge, before the capture registers are valid.
    assign cur_idx    = (state_q == IDLE) ? live_idx : idx_q;
    assign cur_bad    = (state_q == IDLE) ? live_bad : bad_q;
    assign cur_wr     = (state_q == IDLE) ? write    : is_wr_q;
    assign enter_done = (state_q != DONE) && (state_d == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (read || write) begin
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!read && !write) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == 3'd1) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            readdata_q <= 32'd0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            bad_q      <= 1'b0;
            is_wr_q    <= 1'b0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= live_idx;
                bad_q   <= live_bad;
                is_wr_q <= write;
                be_q    <= byteenable;
                wdata_q <= writedata;
            end
            if (enter_done) begin
                if (cur_bad) begin
                    readdata_q <= 32'd0;
                    err_q      <= 1'b1;
                end else if (!cur_wr) begin
                    readdata_q <= mem[cur_idx];
                end
            end
        end
    end

    // Array is never reset; a write commits on the edge that ends DONE unless reset is asserted there.
    always_ff @(posedge clk) begin
        if (reset && (state_q == DONE) && is_wr_q && !bad_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign waitrequest = (state_q != DONE);
    assign readdata    = readdata_q;
    assign err         = err_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 4, 1) sharing a clock, exercised one at a time
// with a directed vector table, hand-written multi-cycle sequences and a randomized run against a word-array model.
module tb_avalon_mem_responder;

    localparam logic [31:0] B = 32'h00001000;
    localparam int          D = 64;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [31:0] addr  [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [3:0]  be    [3];
    logic [31:0] wdat  [3];
    logic        wreq  [3];
    logic [31:0] rdata [3];
    logic        errs  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_mem_responder #(.BASE_ADDR(B), .DEPTH_WORDS(D), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .address(addr[0]), .read(rd[0]), .write(wr[0]),
        .byteenable(be[0]), .writedata(wdat[0]), .waitrequest(wreq[0]), .readdata(rdata[0]), .err(errs[0]));
    avalon_mem_responder #(.BASE_ADDR(B), .DEPTH_WORDS(D), .LATENCY(4)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .address(addr[1]), .read(rd[1]), .write(wr[1]),
        .byteenable(be[1]), .writedata(wdat[1]), .waitrequest(wreq[1]), .readdata(rdata[1]), .err(errs[1]));
    avalon_mem_responder #(.BASE_ADDR(B), .DEPTH_WORDS(D), .LATENCY(1)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .address(addr[2]), .read(rd[2]), .write(wr[2]),
        .byteenable(be[2]), .writedata(wdat[2]), .waitrequest(wreq[2]), .readdata(rdata[2]), .err(errs[2]));

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [18];

    logic [31:0] model [D];
    bit          err_m;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    // Starts just after a posedge with the DUT idle; ends just after the posedge that closes DONE.
    task automatic xfer(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] a_late, input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd_got, output logic err_got, output int n);
        rd[k] = r; wr[k] = w; addr[k] = a; wdat[k] = d; be[k] = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (!wreq[k]) break;
            if (n > 16) begin
                checks++;
                errors++;
                $display("FAIL timeout dut%0d waitrequest stuck at 1 required 0", k);
                n = 99;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n == 1) addr[k] = a_late;
        end
        rd_got = rdata[k];
        err_got = errs[k];
        @(posedge clk); #1;
        rd[k] = 1'b0; wr[k] = 1'b0;
    endtask

    task automatic do_reset(input int k);
        rst_n[k] = 1'b0;
        @(posedge clk); #1;
        rst_n[k] = 1'b1;
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a >= B) && (a < B + 32'(4 * D)) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) if (b[i]) res[8*i +: 8] = d[8*i +: 8];
        return res;
    endfunction

    initial begin
        logic [31:0] got_rd, a;
        logic        got_err;
        int          n, j, sel;
        bit          r, w, bad;
        logic [31:0] d, exp;
        logic [3:0]  b;
        logic [31:0] vals [4];

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'd0; be[k] = 4'd0; wdat[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_wreq%0d", k), 32'(wreq[k]), 32'd1);
            chk($sformatf("reset_rdata%0d", k), rdata[k], 32'd0);
            chk($sformatf("reset_err%0d", k), 32'(errs[k]), 32'd0);
        end
        @(posedge clk); #1;

        // Directed vectors on the LATENCY=2 responder
        tbl[0]  = '{1'b0, 1'b1, B + 32'd8,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, B + 32'd8,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, B + 32'd12,  32'h11223344, 4'hF, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 1'b1, B + 32'd12,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 1'b0, B + 32'd12,  32'h0,        4'hF, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, B + 32'd16,  32'h01020304, 4'hF, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 1'b1, B + 32'd16,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 1'b0, B + 32'd16,  32'h0,        4'h0, 32'h01020304, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, B + 32'd252, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 1'b0, B + 32'd252, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        tbl[10] = '{1'b1, 1'b0, B + 32'd256, 32'h0,        4'h0, 32'h0,        1'b1};
        tbl[11] = '{1'b1, 1'b0, B + 32'd2,   32'h0,        4'h0, 32'h0,        1'b1};
        tbl[12] = '{1'b1, 1'b0, B + 32'd8,   32'h0,        4'h0, 32'hDEADBEEF, 1'b1};
        tbl[13] = '{1'b1, 1'b1, B + 32'd8,   32'h0,        4'hF, 32'h0,        1'b1};
        tbl[14] = '{1'b1, 1'b0, B + 32'd8,   32'h0,        4'h0, 32'hDEADBEEF, 1'b1};
        tbl[15] = '{1'b0, 1'b1, B + 32'd10,  32'h0,        4'hF, 32'h0,        1'b1};
        tbl[16] = '{1'b1, 1'b0, B + 32'd8,   32'h0,        4'h0, 32'hDEADBEEF, 1'b1};
        tbl[17] = '{1'b1, 1'b0, B - 32'd4,   32'h0,        4'h0, 32'h0,        1'b1};

        for (int i = 0; i < 18; i++) begin
            xfer(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].a, tbl[i].d, tbl[i].b, got_rd, got_err, n);
            chk($sformatf("vec%0d_lat", i), 32'(n), 32'd2);
            chk($sformatf("vec%0d_err", i), 32'(got_err), 32'(tbl[i].exp_err));
            if (tbl[i].r) chk($sformatf("vec%0d_rdata", i), got_rd, tbl[i].exp_rd);
        end

        do_reset(0);
        @(negedge clk);
        chk("dut0_err_cleared", 32'(errs[0]), 32'd0);
        chk("dut0_rdata_cleared", rdata[0], 32'd0);
        @(posedge clk); #1;

        // Reset during WAIT discards the pending write (LATENCY=4)
        xfer(1, 1'b0, 1'b1, B + 32'd20, B + 32'd20, 32'hA5A5A5A5, 4'hF, got_rd, got_err, n);
        chk("l4_wr_lat", 32'(n), 32'd4);
        xfer(1, 1'b1, 1'b0, B + 32'd1, B + 32'd1, 32'h0, 4'h0, got_rd, got_err, n);
        chk("l4_bad_err", 32'(got_err), 32'd1);
        chk("l4_bad_rdata", got_rd, 32'd0);
        wr[1] = 1'b1; addr[1] = B + 32'd20; wdat[1] = 32'h5A5A5A5A; be[1] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        @(negedge clk);
        chk("l4_wait_wreq", 32'(wreq[1]), 32'd1);
        @(posedge clk); #1;
        rst_n[1] = 1'b1; wr[1] = 1'b0;
        @(negedge clk);
        chk("l4_rst_wreq", 32'(wreq[1]), 32'd1);
        chk("l4_rst_err", 32'(errs[1]), 32'd0);
        chk("l4_rst_rdata", rdata[1], 32'd0);
        @(posedge clk); #1;
        xfer(1, 1'b1, 1'b0, B + 32'd20, B + 32'd20, 32'h0, 4'h0, got_rd, got_err, n);
        chk("l4_rd_lat", 32'(n), 32'd4);
        chk("l4_rd_prewrite", got_rd, 32'hA5A5A5A5);

        // Abort in WAIT, then a read whose address moves after acceptance
        xfer(1, 1'b0, 1'b1, B + 32'd24, B + 32'd24, 32'h0BADF00D, 4'hF, got_rd, got_err, n);
        wr[1] = 1'b1; addr[1] = B + 32'd24; wdat[1] = 32'h12345678; be[1] = 4'hF;
        @(posedge clk); #1;
        wr[1] = 1'b0;
        @(negedge clk);
        chk("abort_wreq", 32'(wreq[1]), 32'd1);
        @(posedge clk); #1;
        xfer(1, 1'b1, 1'b0, B + 32'd24, B + 32'd20, 32'h0, 4'h0, got_rd, got_err, n);
        chk("abort_rd_lat", 32'(n), 32'd4);
        chk("abort_rd_data", got_rd, 32'h0BADF00D);
        chk("abort_err", 32'(got_err), 32'd0);

        // Back-to-back held reads at LATENCY=1
        vals[0] = 32'h10101010; vals[1] = 32'h20202020; vals[2] = 32'h30303030; vals[3] = 32'h40404040;
        for (int i = 0; i < 4; i++) begin
            xfer(2, 1'b0, 1'b1, B + 32'(4 * i), B + 32'(4 * i), vals[i], 4'hF, got_rd, got_err, n);
            chk($sformatf("l1_wr%0d_lat", i), 32'(n), 32'd1);
        end
        j = 0;
        rd[2] = 1'b1; addr[2] = B;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_wreq%0d", c), 32'(wreq[2]), (c % 2 == 0) ? 32'd1 : 32'd0);
            if (c % 2 == 1) chk($sformatf("b2b_rdata%0d", c), rdata[2], vals[j]);
            @(posedge clk); #1;
            if (c % 2 == 1) begin
                j++;
                addr[2] = B + 32'(4 * (j % 4));
            end
        end
        rd[2] = 1'b0;

        // Randomized run on the LATENCY=2 responder against the word-array model
        do_reset(0);
        err_m = 1'b0;
        for (int i = 0; i < D; i++) begin
            model[i] = $urandom;
            xfer(0, 1'b0, 1'b1, B + 32'(4 * i), B + 32'(4 * i), model[i], 4'hF, got_rd, got_err, n);
        end
        for (int t = 0; t < 200; t++) begin
            sel = int'($urandom_range(0, 99));
            a = B + 32'(4 * $urandom_range(0, D - 1));
            r = 1'b0; w = 1'b0;
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            if (sel < 10) begin
                r = 1'b1;
                case ($urandom_range(0, 3))
                    0: a = B - 32'(4 * $urandom_range(1, 8));
                    1: a = B + 32'(4 * D) + 32'(4 * $urandom_range(0, 15));
                    2: a = a + 32'($urandom_range(1, 3));
                    default: a = 32'hFFFFFFFC;
                endcase
                if (sel < 4) begin r = 1'b0; w = 1'b1; end
            end else if (sel < 15) begin
                r = 1'b1; w = 1'b1;
            end else if (sel < 55) begin
                r = 1'b1;
            end else begin
                w = 1'b1;
            end
            bad = !legal(a) || (r && w);
            xfer(0, r, w, a, a, d, b, got_rd, got_err, n);
            exp = 32'd0;
            if (!bad) begin
                if (w) model[(a - B) >> 2] = merge(model[(a - B) >> 2], d, b);
                else   exp = model[(a - B) >> 2];
            end
            err_m = err_m | bad;
            chk($sformatf("rnd%0d_lat", t), 32'(n), 32'd2);
            chk($sformatf("rnd%0d_err", t), 32'(got_err), 32'(err_m));
            if (r) chk($sformatf("rnd%0d_rdata a=%h", t, a), got_rd, exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
